sort_result_monitor: RTL and testbench
======================================

Name: sort_result_monitor

Overview:
- Consumes the observation outputs of RISC_V_Processor: element1..element8 memory taps plus stall and flush.
- Sits directly downstream of the processor in simulation and on-chip debug.
- Decides when the in-memory bubble sort has completed and checks that the result is ordered.
- Reports cycle, stall and flush counts and a sticky done/pass/timeout verdict.

Parameters:
- STABLE_CYCLES, 16: consecutive sorted-and-unchanged cycles required to declare completion (>=1).
- TIMEOUT_CYCLES, 4096: active-cycle limit before declaring timeout.
- CNT_W, 32: width of all counters.
- SIGNED_CMP, 1: 1 = signed 64-bit ordering (matches blt/bge); 0 = unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- element1..element8  in  64 each  processor data-memory taps, element1 = lowest address.
- stall  in  1  processor hazard-stall indicator.
- flush  in  1  processor branch-flush indicator.
- done  out  1  sticky, verdict reached.
- sorted_ok  out  1  sticky, completed with ascending order.
- timeout  out  1  sticky, limit hit before completion.
- cycle_count  out  CNT_W  active cycles elapsed.
- stall_count  out  CNT_W  active cycles with stall=1.
- flush_count  out  CNT_W  active cycles with flush=1.
- last_change_cycle  out  CNT_W  index of last active cycle in which any element changed.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset state:
  - state=IDLE.
  - All outputs 0.
  - Snapshot registers snap1..snap8 = 0.
  - stable_cnt = 0.
- States:
  - IDLE: one edge with reset=0. Load snap<=elements, go to RUN. No counting.
  - RUN: active. Each edge, cycle_count += 1. The new value is the current cycle index k, 1-based.
    - stall_count += stall; flush_count += flush.
    - changed = any element != its snap. If changed, last_change_cycle <= k.
    - snap <= elements every RUN edge.
    - sorted = element(i) <= element(i+1) for i=1..7, compared per SIGNED_CMP. Equal values count as sorted.
    - If sorted && !changed: stable_cnt += 1. Otherwise stable_cnt <= 0.
    - If the incremented stable_cnt == STABLE_CYCLES: go to DONE, done<=1, sorted_ok<=1.
    - Else if k == TIMEOUT_CYCLES: go to TIMEOUT, done<=1, timeout<=1, sorted_ok stays 0.
  - DONE / TIMEOUT: terminal until reset. All counters and outputs frozen. Inputs ignored.
- Simultaneous events:
  - Completion and timeout on the same edge: DONE wins.
  - stall and flush both high: both counters increment.
- Counters saturate at all-ones and never wrap. stable_cnt is internal and wide enough for STABLE_CYCLES.
- Reset asserted in any state, including mid-RUN: returns to the reset state on that edge. Nothing is retained.
- Outputs are registered: no combinational path from inputs to outputs. Latency from the qualifying input cycle to done is 1 edge.

Test Plan:
1. Constant 1,2,...,8, STABLE_CYCLES=16, reset released → edge 1 IDLE→RUN. Done=1 and sorted_ok=1 after edge 17. cycle_count=16, last_change_cycle=0, timeout=0.
2. Hold 8,7,...,1 for active cycles 1–10, apply 1..8 from cycle 11 onward → last_change_cycle=11. Done after active cycle 27, cycle_count=27, sorted_ok=1.
3. With scenario 1 stimulus, stall=1 during active cycles 3–7 and flush=1 in cycles 5 and 9, plus stall pulses after DONE → stall_count=5, flush_count=2. Post-DONE pulses are not counted.
4. TIMEOUT_CYCLES=64, constant unsorted 2,1,3..8 → after active cycle 64: done=1, timeout=1, sorted_ok=0, cycle_count=64. Values stay frozen for 20 further cycles.
5. Elements -5 (0xFFFFFFFFFFFFFFFB),3,4..9 constant → SIGNED_CMP=1: sorted_ok=1 after edge 17. SIGNED_CMP=0 with TIMEOUT_CYCLES=64: timeout=1. STABLE_CYCLES=64=TIMEOUT_CYCLES with sorted input: DONE wins, sorted_ok=1, timeout=0.
6. Scenario 2 stimulus, reset=1 for one edge at active cycle 8, then released → all outputs 0 on the next edge. Restart from IDLE: cycle_count counts again from 1, last_change_cycle=0 until a new change occurs.

Source files
------------

// File: rtl/sort_result_monitor.sv
// Watches the processor's memory taps, declares the bubble sort finished once the array is
// ordered and unchanged for STABLE_CYCLES, and keeps sticky verdicts plus activity counters.
module sort_result_monitor #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 32,
    parameter bit          SIGNED_CMP     = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      element1,
    input  logic [63:0]      element2,
    input  logic [63:0]      element3,
    input  logic [63:0]      element4,
    input  logic [63:0]      element5,
    input  logic [63:0]      element6,
    input  logic [63:0]      element7,
    input  logic [63:0]      element8,
    input  logic             stall,
    input  logic             flush,
    output logic             done,
    output logic             sorted_ok,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] last_change_cycle
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StTimeout} state_e;

    state_e           state_q, state_d;
    logic [63:0]      snap_q [8];
    logic [63:0]      snap_d [8];
    logic [63:0]      elem   [8];
    logic [SW-1:0]    stable_q, stable_d, stable_inc;
    logic [CNT_W-1:0] cyc_q, cyc_d, stall_q, stall_d, flush_q, flush_d, last_q, last_d, k;
    logic             done_q, done_d, ok_q, ok_d, to_q, to_d;
    logic             changed, sorted;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        elem[0] = element1;
        elem[1] = element2;
        elem[2] = element3;
        elem[3] = element4;
        elem[4] = element5;
        elem[5] = element6;
        elem[6] = element7;
        elem[7] = element8;
    end

    always_comb begin
        changed = 1'b0;
        sorted  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (elem[i] != snap_q[i]) changed = 1'b1;
        end
        for (int i = 0; i < 7; i++) begin
            if (SIGNED_CMP) begin
                if ($signed(elem[i]) > $signed(elem[i+1])) sorted = 1'b0;
            end else begin
                if (elem[i] > elem[i+1]) sorted = 1'b0;
            end
        end
    end

    assign k          = sat_inc(cyc_q);
    assign stable_inc = stable_q + SW'(1);

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        stable_d = stable_q;
        cyc_d    = cyc_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        last_d   = last_q;
        done_d   = done_q;
        ok_d     = ok_q;
        to_d     = to_q;
        unique case (state_q)
            StIdle: begin
                snap_d  = elem;
                state_d = StRun;
            end
            StRun: begin
                cyc_d  = k;
                snap_d = elem;
                if (stall) stall_d = sat_inc(stall_q);
                if (flush) flush_d = sat_inc(flush_q);
                if (changed) last_d = k;
                stable_d = (sorted && !changed) ? stable_inc : '0;
                // Completion is tested first so it wins over a coincident timeout.
                if (sorted && !changed && stable_inc == SW'(STABLE_CYCLES)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                end else if (k == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = StTimeout;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end
            end
            StDone, StTimeout: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            for (int i = 0; i < 8; i++) snap_q[i] <= '0;
            stable_q <= '0;
            cyc_q    <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            last_q   <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            stable_q <= stable_d;
            cyc_q    <= cyc_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            last_q   <= last_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            to_q     <= to_d;
        end
    end

    assign done              = done_q;
    assign sorted_ok         = ok_q;
    assign timeout           = to_q;
    assign cycle_count       = cyc_q;
    assign stall_count       = stall_q;
    assign flush_count       = flush_q;
    assign last_change_cycle = last_q;

endmodule

// File: tb/tb_sort_result_monitor.sv
// Directed bench: four monitor instances with different parameters share one stimulus stream.
module tb_sort_result_monitor;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [63:0] el [8];
    logic        done_w [4];
    logic        ok_w   [4];
    logic        to_w   [4];
    logic [31:0] cyc_w  [4];
    logic [31:0] stl_w  [4];
    logic [31:0] fl_w   [4];
    logic [31:0] last_w [4];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: timeout 64, 2: unsigned + timeout 64, 3: stable 64 == timeout 64
    sort_result_monitor #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(4096), .CNT_W(32), .SIGNED_CMP(1'b1))
    u_dut0 (
        .clk(clk), .reset(reset), .element1(el[0]), .element2(el[1]), .element3(el[2]),
        .element4(el[3]), .element5(el[4]), .element6(el[5]), .element7(el[6]), .element8(el[7]),
        .stall(stall), .flush(flush), .done(done_w[0]), .sorted_ok(ok_w[0]), .timeout(to_w[0]),
        .cycle_count(cyc_w[0]), .stall_count(stl_w[0]), .flush_count(fl_w[0]),
        .last_change_cycle(last_w[0])
    );
    sort_result_monitor #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(64), .CNT_W(32), .SIGNED_CMP(1'b1))
    u_dut1 (
        .clk(clk), .reset(reset), .element1(el[0]), .element2(el[1]), .element3(el[2]),
        .element4(el[3]), .element5(el[4]), .element6(el[5]), .element7(el[6]), .element8(el[7]),
        .stall(stall), .flush(flush), .done(done_w[1]), .sorted_ok(ok_w[1]), .timeout(to_w[1]),
        .cycle_count(cyc_w[1]), .stall_count(stl_w[1]), .flush_count(fl_w[1]),
        .last_change_cycle(last_w[1])
    );
    sort_result_monitor #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(64), .CNT_W(32), .SIGNED_CMP(1'b0))
    u_dut2 (
        .clk(clk), .reset(reset), .element1(el[0]), .element2(el[1]), .element3(el[2]),
        .element4(el[3]), .element5(el[4]), .element6(el[5]), .element7(el[6]), .element8(el[7]),
        .stall(stall), .flush(flush), .done(done_w[2]), .sorted_ok(ok_w[2]), .timeout(to_w[2]),
        .cycle_count(cyc_w[2]), .stall_count(stl_w[2]), .flush_count(fl_w[2]),
        .last_change_cycle(last_w[2])
    );
    sort_result_monitor #(.STABLE_CYCLES(64), .TIMEOUT_CYCLES(64), .CNT_W(32), .SIGNED_CMP(1'b1))
    u_dut3 (
        .clk(clk), .reset(reset), .element1(el[0]), .element2(el[1]), .element3(el[2]),
        .element4(el[3]), .element5(el[4]), .element6(el[5]), .element7(el[6]), .element8(el[7]),
        .stall(stall), .flush(flush), .done(done_w[3]), .sorted_ok(ok_w[3]), .timeout(to_w[3]),
        .cycle_count(cyc_w[3]), .stall_count(stl_w[3]), .flush_count(fl_w[3]),
        .last_change_cycle(last_w[3])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_asc();
        for (int i = 0; i < 8; i++) el[i] = 64'(i + 1);
    endtask

    task automatic set_desc();
        for (int i = 0; i < 8; i++) el[i] = 64'(8 - i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, ".done"}, 64'(done_w[d]), 64'd0);
        chk({tag, ".sorted_ok"}, 64'(ok_w[d]), 64'd0);
        chk({tag, ".timeout"}, 64'(to_w[d]), 64'd0);
        chk({tag, ".cycle"}, 64'(cyc_w[d]), 64'd0);
        chk({tag, ".stall"}, 64'(stl_w[d]), 64'd0);
        chk({tag, ".flush"}, 64'(fl_w[d]), 64'd0);
        chk({tag, ".last"}, 64'(last_w[d]), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_asc();
        do_reset();
        chk_zero(0, "rst");

        // Sorted constant input with stall/flush activity
        tick();
        chk("s1.idle_nocount", 64'(cyc_w[0]), 64'd0);
        for (int k = 1; k <= 16; k++) begin
            stall = (k >= 3 && k <= 7);
            flush = (k == 5 || k == 9);
            tick();
            if (k == 15) chk("s1.done_early", 64'(done_w[0]), 64'd0);
        end
        stall = 1'b0;
        flush = 1'b0;
        chk("s1.done", 64'(done_w[0]), 64'd1);
        chk("s1.sorted_ok", 64'(ok_w[0]), 64'd1);
        chk("s1.timeout", 64'(to_w[0]), 64'd0);
        chk("s1.cycle", 64'(cyc_w[0]), 64'd16);
        chk("s1.last", 64'(last_w[0]), 64'd0);
        chk("s3.stall", 64'(stl_w[0]), 64'd5);
        chk("s3.flush", 64'(fl_w[0]), 64'd2);
        stall = 1'b1;
        flush = 1'b1;
        set_desc();
        repeat (3) tick();
        stall = 1'b0;
        flush = 1'b0;
        chk("s3.frozen_stall", 64'(stl_w[0]), 64'd5);
        chk("s3.frozen_flush", 64'(fl_w[0]), 64'd2);
        chk("s3.frozen_cycle", 64'(cyc_w[0]), 64'd16);
        chk("s3.frozen_ok", 64'(ok_w[0]), 64'd1);

        // Descending for 10 active cycles, then ascending
        set_desc();
        do_reset();
        tick();
        for (int k = 1; k <= 27; k++) begin
            if (k == 11) set_asc();
            tick();
            if (k == 26) chk("s2.done_early", 64'(done_w[0]), 64'd0);
        end
        chk("s2.done", 64'(done_w[0]), 64'd1);
        chk("s2.sorted_ok", 64'(ok_w[0]), 64'd1);
        chk("s2.cycle", 64'(cyc_w[0]), 64'd27);
        chk("s2.last", 64'(last_w[0]), 64'd11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero(0, "s2.rst_after_done");

        // Reset in the middle of RUN, then restart
        set_desc();
        do_reset();
        tick();
        repeat (7) tick();
        chk("s6.cycle_pre", 64'(cyc_w[0]), 64'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero(0, "s6.mid");
        tick();
        tick();
        chk("s6.cycle1", 64'(cyc_w[0]), 64'd1);
        chk("s6.last0", 64'(last_w[0]), 64'd0);
        set_asc();
        tick();
        chk("s6.cycle2", 64'(cyc_w[0]), 64'd2);
        chk("s6.last2", 64'(last_w[0]), 64'd2);

        // Constant unsorted input: timeout after 64 active cycles
        set_asc();
        el[0] = 64'd2;
        el[1] = 64'd1;
        do_reset();
        tick();
        repeat (63) tick();
        chk("s4.done_early", 64'(done_w[1]), 64'd0);
        tick();
        chk("s4.done", 64'(done_w[1]), 64'd1);
        chk("s4.timeout", 64'(to_w[1]), 64'd1);
        chk("s4.sorted_ok", 64'(ok_w[1]), 64'd0);
        chk("s4.cycle", 64'(cyc_w[1]), 64'd64);
        repeat (20) tick();
        chk("s4.frozen_cycle", 64'(cyc_w[1]), 64'd64);
        chk("s4.frozen_timeout", 64'(to_w[1]), 64'd1);
        chk("s4.dut0_running", 64'(cyc_w[0]), 64'd84);
        chk("s4.dut0_notdone", 64'(done_w[0]), 64'd0);

        // -5,3,4..9: ordered only under signed comparison
        el[0] = 64'hFFFF_FFFF_FFFF_FFFB;
        for (int i = 1; i < 8; i++) el[i] = 64'(i + 2);
        do_reset();
        tick();
        repeat (16) tick();
        chk("s5.signed_done", 64'(done_w[0]), 64'd1);
        chk("s5.signed_ok", 64'(ok_w[0]), 64'd1);
        chk("s5.unsigned_notdone", 64'(done_w[2]), 64'd0);
        repeat (47) tick();
        chk("s5.eq_done_early", 64'(done_w[3]), 64'd0);
        tick();
        chk("s5.unsigned_timeout", 64'(to_w[2]), 64'd1);
        chk("s5.unsigned_ok", 64'(ok_w[2]), 64'd0);
        chk("s5.eq_done", 64'(done_w[3]), 64'd1);
        chk("s5.eq_ok", 64'(ok_w[3]), 64'd1);
        chk("s5.eq_timeout", 64'(to_w[3]), 64'd0);
        chk("s5.eq_cycle", 64'(cyc_w[3]), 64'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
